uspispy_flash_ctrl: RTL and testbench
=====================================

Name: uspispy_flash_ctrl

Overview:
- Commit controller behind the uspispy QSPI mux.
- Consumes logged SPI commands in the clk domain and performs Page Program (0x02) and 4 KB Sector Erase (0x20) against the two PSRAM chips. Source data is the spi_clk-side write buffer.
- Arbitrates PSRAM access against PCH reads through a request/grant handshake, splits bursts at PSRAM page boundaries, and reports completion by writing the status register back to the mux.

Parameters:
- RAM_PAGE, 1024: PSRAM burst page in bytes; CS must drop before crossing a page.
- BUF_BASE, 1: write-buffer index of program data byte 0.
- GAP_CYCLES, 4: minimum clk cycles with ram_req low between bursts.
- ERASE_SIZE, 4096: erase sector size; power of two.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_strobe  in  1  one-cycle pulse; command logged by the mux
- cmd  in  8  command opcode
- cmd_addr  in  24  flash address
- cmd_len  in  12  total bytes in the transaction, including opcode and 3 address bytes
- sr_cur  in  8  current status register from the mux
- sr_out  out  8  new status register value
- sr_strobe  out  1  one-cycle pulse; mux loads sr_out
- buf_addr  out  8  write-buffer read address
- buf_data  in  8  write-buffer read data, valid 1 cycle after buf_addr
- ram_req  out  1  request PSRAM bus; stays high for the whole burst and acts as CS
- ram_grant  in  1  bus granted; low whenever PCH CS is active
- ram_sel  out  1  chip select: 0 = ram0, 1 = ram1
- ram_tx_byte  out  8  byte to shift out to the PSRAM
- ram_tx_valid  out  1  ram_tx_byte valid
- ram_tx_ready  in  1  shifter accepted the byte this cycle
- busy  out  1  operation in progress

Behaviour:
- Reset values: every output is 0; state is IDLE.
- Command accept:
  - cmd_strobe is accepted only in IDLE. A strobe while busy is dropped and counted nowhere.
  - Opcodes other than 0x02 and 0x20 are ignored with no sr_strobe.
- CHECK, one cycle after accept:
  - Reject when sr_cur[1] (WEL) = 0, or when the opcode is 0x02 and cmd_len < 5.
  - On reject: sr_out = sr_cur & 8'hFC, pulse sr_strobe, return to IDLE.
- Program:
  - n = min(cmd_len - 4, 256).
  - Byte k goes to address {cmd_addr[23:8], (cmd_addr[7:0] + k) mod 256}; this is NOR page wrap.
  - Byte k comes from buf_addr = BUF_BASE + k, mod 256.
- Erase:
  - Base address = cmd_addr & ~(ERASE_SIZE - 1).
  - Writes ERASE_SIZE bytes of 8'hFF; the write buffer is not read.
- States: IDLE -> CHECK -> REQ -> HDR (4 bytes: 8'h02, A[23:16], A[15:8], A[7:0]) -> DATA -> GAP -> REQ ... -> DONE -> IDLE.
- Address mapping:
  - ram_sel = current address bit 23.
  - Header address = {1'b0, addr[22:0]}.
- REQ:
  - Raise ram_req and wait for ram_grant.
  - ram_sel is stable from REQ through the end of the burst.
- Byte handshake:
  - ram_tx_valid and ram_tx_byte are held until the cycle in which ram_tx_ready = 1.
  - A byte counts as transferred only on that cycle.
- Burst end: the burst ends, passing to GAP and then REQ with a fresh header, when any of these holds:
  - The next address crosses a RAM_PAGE boundary.
  - The program address wraps 0xFF -> 0x00 in bits [7:0].
  - Bit 23 of the address changes.
- Grant loss:
  - If ram_grant drops during HDR or DATA, drop ram_req on the next cycle without waiting for the current byte.
  - Untransferred bytes are retried later: GAP, then REQ, then a new header at the first untransferred address.
- GAP holds ram_req low for exactly GAP_CYCLES cycles.
- DONE: sr_out = sr_cur & 8'hFC (WIP and WEL cleared), sr_strobe pulses for 1 cycle, busy falls on the next cycle.
- busy is high from CHECK through DONE.
- Reset mid-operation: all outputs drop asynchronously to 0. No completion strobe is issued.

Decomposition:
- Shared package uspispy_pkg: opcode constants (CMD_PP3 = 8'h02, CMD_ERASE = 8'h20, RAM_CMD_WRITE = 8'h02), SR bit indices (SR_WIP = 0, SR_WEL = 1), and the state enum.
- One natural sub-module, uspispy_burst_gen: holds the address and remaining-count registers and produces the end-of-burst decision (page, wrap and chip-crossing checks).

Test Plan:
- PP3, addr 0x000010, len 8, WEL = 1, grant tied high, buffer[1..4] = 11 22 33 44:
  - ram0 receives 02 00 00 10 11 22 33 44 in one burst.
  - One sr_strobe with sr_out = 0x00 (sr_cur = 0x03).
- PP3, addr 0x0000FE, len 8, bytes AA BB CC DD:
  - Burst 1: 02 00 00 FE AA BB.
  - GAP of 4 cycles with ram_req low.
  - Burst 2: 02 00 00 00 CC DD.
- Erase, addr 0x800123, WEL = 1:
  - ram1 selected; base 0x800000.
  - 4 bursts of 1024 bytes of FF, headers 02 00 00 00, 02 00 04 00, 02 00 08 00, 02 00 0C 00.
  - Then sr_strobe.
- PP3 with WEL = 0 (sr_cur = 0x01):
  - No ram_req.
  - sr_strobe after 1 cycle with sr_out = 0x00.
- ram_grant dropped after 2 data bytes of a 4-byte program to 0x000010:
  - ram_req falls; later re-request.
  - Header 02 00 00 12, then remaining 2 bytes; a single completion strobe.
- Reset asserted during DATA:
  - ram_req, busy, sr_strobe all 0 immediately.
  - No sr_strobe after release; a new cmd_strobe is accepted.

Source files
------------

// File: rtl/uspispy_pkg.sv
// Shared opcodes, status-register bit positions and controller states for the uspispy commit path.
package uspispy_pkg;

   localparam logic [7:0] CMD_PP3       = 8'h02;
   localparam logic [7:0] CMD_ERASE     = 8'h20;
   localparam logic [7:0] RAM_CMD_WRITE = 8'h02;

   localparam int SR_WIP = 0;
   localparam int SR_WEL = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_REQ,
      ST_HDR,
      ST_DATA,
      ST_GAP,
      ST_DONE
   } state_t;

   // Completion and rejection both report the status register with WIP and WEL cleared.
   function automatic logic [7:0] sr_clear(input logic [7:0] sr);
      logic [7:0] r;
      r         = sr;
      r[SR_WIP] = 1'b0;
      r[SR_WEL] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/uspispy_burst_gen.sv
// Address / remaining-byte tracker; flags when the next byte must start a new PSRAM burst.
module uspispy_burst_gen #(
   parameter int RAM_PAGE = 1024
) (
   input  logic        clk,
   input  logic        load,
   input  logic [23:0] load_addr,
   input  logic [12:0] load_count,
   input  logic        load_prog,
   input  logic        step,
   output logic [23:0] addr,
   output logic        last,
   output logic        burst_end
);

   localparam int PAGE_BITS = $clog2(RAM_PAGE);

   logic        prog;
   logic [12:0] remain;
   logic [23:0] next_addr;

   // Program wraps inside the 256-byte NOR page; erase walks the whole sector linearly.
   always_comb begin
      next_addr = prog ? {addr[23:8], addr[7:0] + 8'd1} : addr + 24'd1;
      last      = (remain == 13'd1);
      burst_end = (next_addr[PAGE_BITS-1:0] == '0)
                  || (prog && (next_addr[7:0] == 8'h00))
                  || (next_addr[23] != addr[23]);
   end

   // Position only advances on a byte the shifter actually accepted.
   always_ff @(posedge clk) begin
      if (load) begin
         addr   <= load_addr;
         remain <= load_count;
         prog   <= load_prog;
      end else if (step) begin
         addr   <= next_addr;
         remain <= remain - 13'd1;
      end
   end

endmodule

// File: rtl/uspispy_flash_ctrl.sv
// Commit controller: replays logged Page Program / Sector Erase commands into the two PSRAM chips.
module uspispy_flash_ctrl #(
   parameter int RAM_PAGE   = 1024,
   parameter int BUF_BASE   = 1,
   parameter int GAP_CYCLES = 4,
   parameter int ERASE_SIZE = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_strobe,
   input  logic [7:0]  cmd,
   input  logic [23:0] cmd_addr,
   input  logic [11:0] cmd_len,
   input  logic [7:0]  sr_cur,
   output logic [7:0]  sr_out,
   output logic        sr_strobe,
   output logic [7:0]  buf_addr,
   input  logic [7:0]  buf_data,
   output logic        ram_req,
   input  logic        ram_grant,
   output logic        ram_sel,
   output logic [7:0]  ram_tx_byte,
   output logic        ram_tx_valid,
   input  logic        ram_tx_ready,
   output logic        busy
);

   import uspispy_pkg::*;

   localparam logic [23:0] ERASE_MASK  = 24'(ERASE_SIZE - 1);
   localparam logic [12:0] ERASE_COUNT = 13'(ERASE_SIZE);
   localparam logic [7:0]  BUF_START   = 8'(BUF_BASE);
   localparam logic [7:0]  GAP_LAST    = 8'(GAP_CYCLES - 1);

   state_t      state;
   logic        is_prog;
   logic [23:0] op_addr;
   logic [11:0] op_len;
   logic [1:0]  hdr_idx;
   logic [7:0]  gap_cnt;
   logic        fetch_wait;

   logic        pass;
   logic        load;
   logic        step;
   logic [23:0] start_addr;
   logic [12:0] start_count;
   logic [23:0] cur_addr;
   logic        last;
   logic        burst_end;

   // Program length is the payload after opcode + 3 address bytes, capped at one NOR page.
   function automatic logic [12:0] prog_count(input logic [11:0] len);
      logic [12:0] n;
      n = {1'b0, len} - 13'd4;
      return (n > 13'd256) ? 13'd256 : n;
   endfunction

   // PSRAM write header; the chip select already encodes bit 23.
   function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [23:0] a);
      logic [7:0] b;
      case (idx)
         2'd0:    b = RAM_CMD_WRITE;
         2'd1:    b = {1'b0, a[22:16]};
         2'd2:    b = a[15:8];
         default: b = a[7:0];
      endcase
      return b;
   endfunction

   // Accept check, operation start point and the per-byte advance qualifier.
   always_comb begin
      start_addr  = is_prog ? op_addr : (op_addr & ~ERASE_MASK);
      start_count = is_prog ? prog_count(op_len) : ERASE_COUNT;
      pass        = sr_cur[SR_WEL] && !(is_prog && (op_len < 12'd5));
      load        = (state == ST_CHECK) && pass;
      step        = (state == ST_DATA) && ram_grant && ram_tx_valid && ram_tx_ready;
   end

   uspispy_burst_gen #(
      .RAM_PAGE (RAM_PAGE)
   ) u_burst (
      .clk        (clk),
      .load       (load),
      .load_addr  (start_addr),
      .load_count (start_count),
      .load_prog  (is_prog),
      .step       (step),
      .addr       (cur_addr),
      .last       (last),
      .burst_end  (burst_end)
   );

   // Main sequencer: accept, check, request/header/data bursts with gaps, completion report.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         is_prog      <= 1'b0;
         op_addr      <= '0;
         op_len       <= '0;
         hdr_idx      <= '0;
         gap_cnt      <= '0;
         fetch_wait   <= 1'b0;
         sr_out       <= '0;
         sr_strobe    <= 1'b0;
         buf_addr     <= '0;
         ram_req      <= 1'b0;
         ram_sel      <= 1'b0;
         ram_tx_byte  <= '0;
         ram_tx_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         sr_strobe <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (cmd_strobe && ((cmd == CMD_PP3) || (cmd == CMD_ERASE))) begin
                  is_prog <= (cmd == CMD_PP3);
                  op_addr <= cmd_addr;
                  op_len  <= cmd_len;
                  busy    <= 1'b1;
                  state   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (pass) begin
                  buf_addr <= BUF_START;
                  ram_sel  <= start_addr[23];
                  ram_req  <= 1'b1;
                  state    <= ST_REQ;
               end else begin
                  sr_out    <= sr_clear(sr_cur);
                  sr_strobe <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (ram_grant) begin
                  ram_tx_byte  <= hdr_byte(2'd0, cur_addr);
                  ram_tx_valid <= 1'b1;
                  hdr_idx      <= 2'd0;
                  state        <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (!ram_grant) begin
                  ram_req      <= 1'b0;
                  ram_tx_valid <= 1'b0;
                  gap_cnt      <= GAP_LAST;
                  state        <= ST_GAP;
               end else if (ram_tx_ready) begin
                  if (hdr_idx == 2'd3) begin
                     ram_tx_valid <= 1'b0;
                     fetch_wait   <= 1'b0;
                     state        <= ST_DATA;
                  end else begin
                     hdr_idx     <= hdr_idx + 2'd1;
                     ram_tx_byte <= hdr_byte(hdr_idx + 2'd1, cur_addr);
                  end
               end
            end
            ST_DATA: begin
               if (!ram_grant) begin
                  ram_req      <= 1'b0;
                  ram_tx_valid <= 1'b0;
                  gap_cnt      <= GAP_LAST;
                  state        <= ST_GAP;
               end else if (ram_tx_valid) begin
                  if (ram_tx_ready) begin
                     ram_tx_valid <= 1'b0;
                     fetch_wait   <= is_prog;
                     if (is_prog) buf_addr <= buf_addr + 8'd1;
                     if (last) begin
                        ram_req   <= 1'b0;
                        sr_out    <= sr_clear(sr_cur);
                        sr_strobe <= 1'b1;
                        state     <= ST_DONE;
                     end else if (burst_end) begin
                        ram_req <= 1'b0;
                        gap_cnt <= GAP_LAST;
                        state   <= ST_GAP;
                     end
                  end
               end else if (fetch_wait) begin
                  // buf_data for the new buf_addr lands one cycle later
                  fetch_wait <= 1'b0;
               end else begin
                  ram_tx_byte  <= is_prog ? buf_data : 8'hFF;
                  ram_tx_valid <= 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == 8'd0) begin
                  ram_sel <= cur_addr[23];
                  ram_req <= 1'b1;
                  state   <= ST_REQ;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uspispy_flash_ctrl.sv
// Directed bench for uspispy_flash_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_uspispy_flash_ctrl;

   logic        clk;
   logic        reset;
   logic        cmd_strobe;
   logic [7:0]  cmd;
   logic [23:0] cmd_addr;
   logic [11:0] cmd_len;
   logic [7:0]  sr_cur;
   logic [7:0]  sr_out;
   logic        sr_strobe;
   logic [7:0]  buf_addr;
   logic [7:0]  buf_data;
   logic        ram_req;
   logic        ram_grant;
   logic        ram_sel;
   logic [7:0]  ram_tx_byte;
   logic        ram_tx_valid;
   logic        ram_tx_ready;
   logic        busy;

   uspispy_flash_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_strobe   (cmd_strobe),
      .cmd          (cmd),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .sr_cur       (sr_cur),
      .sr_out       (sr_out),
      .sr_strobe    (sr_strobe),
      .buf_addr     (buf_addr),
      .buf_data     (buf_data),
      .ram_req      (ram_req),
      .ram_grant    (ram_grant),
      .ram_sel      (ram_sel),
      .ram_tx_byte  (ram_tx_byte),
      .ram_tx_valid (ram_tx_valid),
      .ram_tx_ready (ram_tx_ready),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write buffer: one-cycle read latency.
   logic [7:0] mem [256];
   always @(posedge clk) buf_data <= mem[buf_addr];

   // Shifter ready, optionally throttled to exercise the hold rule.
   bit stall_mode = 1'b0;
   int tick = 0;
   always @(negedge clk) begin
      tick++;
      ram_tx_ready = stall_mode ? ((tick % 3) != 2) : 1'b1;
   end

   // Bus monitor.
   logic [7:0]  got[$];
   int          gaps[$];
   int          bursts, strobes, bidx, low_run, hold_viol;
   logic [31:0] cur_hdr, hdr_first, hdr_last;
   logic [7:0]  last_sr, prev_byte;
   bit          last_sel, sel_mixed, hdr_seen, req_prev, prev_stall;

   always @(posedge clk) begin
      if (ram_req && !req_prev) begin
         if (bursts > 0) gaps.push_back(low_run);
         bursts++;
         bidx    = 0;
         low_run = 0;
      end else if (!ram_req) begin
         low_run++;
      end
      req_prev = ram_req;
      if (prev_stall && (!ram_tx_valid || (ram_tx_byte != prev_byte))) hold_viol++;
      prev_stall = ram_tx_valid && !ram_tx_ready && ram_grant;
      prev_byte  = ram_tx_byte;
      if (ram_tx_valid && ram_tx_ready && ram_grant) begin
         if ((got.size() > 0) && (ram_sel != last_sel)) sel_mixed = 1'b1;
         last_sel = ram_sel;
         got.push_back(ram_tx_byte);
         if (bidx < 4) cur_hdr = {cur_hdr[23:0], ram_tx_byte};
         if (bidx == 3) begin
            if (!hdr_seen) hdr_first = cur_hdr;
            hdr_last = cur_hdr;
            hdr_seen = 1'b1;
         end
         bidx++;
      end
      if (sr_strobe) begin
         strobes++;
         last_sr = sr_out;
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      got.delete();
      gaps.delete();
      bursts    = 0;
      strobes   = 0;
      bidx      = 0;
      low_run   = 0;
      hold_viol = 0;
      hdr_seen  = 1'b0;
      sel_mixed = 1'b0;
      hdr_first = '0;
      hdr_last  = '0;
      last_sr   = '0;
   endtask

   task automatic start_cmd(input logic [7:0] op, input logic [23:0] a, input logic [11:0] l,
                            input logic [7:0] sr);
      clear_mon();
      @(negedge clk);
      sr_cur     = sr;
      cmd        = op;
      cmd_addr   = a;
      cmd_len    = l;
      cmd_strobe = 1'b1;
      @(negedge clk);
      cmd_strobe = 1'b0;
   endtask

   task automatic wait_idle(output bit timed_out);
      int cyc;
      cyc = 0;
      while (busy && (cyc < 20000)) begin
         @(negedge clk);
         cyc++;
      end
      timed_out = busy;
      repeat (8) @(negedge clk);
   endtask

   task automatic run_cmd(input logic [7:0] op, input logic [23:0] a, input logic [11:0] l,
                          input logic [7:0] sr, output bit timed_out);
      start_cmd(op, a, l, sr);
      wait_idle(timed_out);
   endtask

   task automatic check_stream(input string name);
      check({name, " len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s byte%0d", name, i),
               (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [23:0] addr;
      logic [11:0] len;
      logic [7:0]  sr;
      bit          stall;
      int          exp_bytes;
      int          exp_bursts;
      logic [31:0] hdr_f;
      logic [31:0] hdr_l;
      bit          sel;
      logic [7:0]  d0;
      logic [7:0]  dl;
      int          exp_strobes;
      logic [7:0]  exp_sr;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   initial begin
      bit to;
      int cyc;
      string nm;

      // Default buffer pattern: mem[i] = 3*i + 1 (mem[0]=01, mem[1]=04, mem[2]=07, mem[4]=0D).
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 1);

      vecs[0]  = '{8'h02, 24'h000010, 12'd8,   8'h03, 1'b0, 8,    1, 32'h02000010, 32'h02000010, 1'b0, 8'h04, 8'h0D, 1, 8'h00};
      vecs[1]  = '{8'h02, 24'h0000FE, 12'd8,   8'h03, 1'b1, 12,   2, 32'h020000FE, 32'h02000000, 1'b0, 8'h04, 8'h0D, 1, 8'h00};
      vecs[2]  = '{8'h20, 24'h800123, 12'd4,   8'h03, 1'b0, 4112, 4, 32'h02000000, 32'h02000C00, 1'b1, 8'hFF, 8'hFF, 1, 8'h00};
      vecs[3]  = '{8'h02, 24'h000010, 12'd8,   8'h01, 1'b0, 0,    0, 32'h0,        32'h0,        1'b0, 8'h00, 8'h00, 1, 8'h00};
      vecs[4]  = '{8'h03, 24'h000010, 12'd8,   8'h03, 1'b0, 0,    0, 32'h0,        32'h0,        1'b0, 8'h00, 8'h00, 0, 8'h00};
      vecs[5]  = '{8'h02, 24'h000010, 12'd4,   8'h02, 1'b0, 0,    0, 32'h0,        32'h0,        1'b0, 8'h00, 8'h00, 1, 8'h00};
      vecs[6]  = '{8'h02, 24'h123400, 12'd300, 8'h83, 1'b0, 260,  1, 32'h02123400, 32'h02123400, 1'b0, 8'h04, 8'h01, 1, 8'h80};
      vecs[7]  = '{8'h02, 24'h812345, 12'd6,   8'h07, 1'b1, 6,    1, 32'h02012345, 32'h02012345, 1'b1, 8'h04, 8'h07, 1, 8'h04};
      vecs[8]  = '{8'h20, 24'h000000, 12'd4,   8'h01, 1'b0, 0,    0, 32'h0,        32'h0,        1'b0, 8'h00, 8'h00, 1, 8'h00};
      vecs[9]  = '{8'h02, 24'h0000FF, 12'd5,   8'h03, 1'b0, 5,    1, 32'h020000FF, 32'h020000FF, 1'b0, 8'h04, 8'h04, 1, 8'h00};
      vecs[10] = '{8'h20, 24'h000FFF, 12'd4,   8'h7E, 1'b0, 4112, 4, 32'h02000000, 32'h02000C00, 1'b0, 8'hFF, 8'hFF, 1, 8'h7C};

      reset      = 1'b0;
      cmd_strobe = 1'b0;
      cmd        = '0;
      cmd_addr   = '0;
      cmd_len    = '0;
      sr_cur     = '0;
      ram_grant  = 1'b1;
      #1;
      check("rst sr_out", sr_out, 0);
      check("rst sr_strobe", sr_strobe, 0);
      check("rst buf_addr", buf_addr, 0);
      check("rst ram_req", ram_req, 0);
      check("rst ram_sel", ram_sel, 0);
      check("rst tx_byte", ram_tx_byte, 0);
      check("rst tx_valid", ram_tx_valid, 0);
      check("rst busy", busy, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Vector table.
      for (int i = 0; i < NV; i++) begin
         stall_mode = vecs[i].stall;
         run_cmd(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].sr, to);
         stall_mode = 1'b0;
         nm = $sformatf("v%0d", i);
         check({nm, " timeout"}, to, 0);
         check({nm, " bytes"}, got.size(), vecs[i].exp_bytes);
         check({nm, " bursts"}, bursts, vecs[i].exp_bursts);
         check({nm, " strobes"}, strobes, vecs[i].exp_strobes);
         if (vecs[i].exp_strobes > 0) check({nm, " sr_out"}, last_sr, vecs[i].exp_sr);
         check({nm, " gap count"}, gaps.size(), (vecs[i].exp_bursts > 0) ? vecs[i].exp_bursts - 1 : 0);
         foreach (gaps[g]) check($sformatf("%s gap%0d", nm, g), gaps[g], 4);
         check({nm, " hold"}, hold_viol, 0);
         check({nm, " busy end"}, busy, 0);
         if ((vecs[i].exp_bytes > 0) && (got.size() == vecs[i].exp_bytes)) begin
            check({nm, " hdr first"}, hdr_first, vecs[i].hdr_f);
            check({nm, " hdr last"}, hdr_last, vecs[i].hdr_l);
            check({nm, " sel"}, last_sel, vecs[i].sel);
            check({nm, " sel stable"}, sel_mixed, 0);
            check({nm, " data first"}, got[4], vecs[i].d0);
            check({nm, " data last"}, got[got.size()-1], vecs[i].dl);
         end
      end

      // Single burst with exact byte stream.
      mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'h44;
      run_cmd(8'h02, 24'h000010, 12'd8, 8'h03, to);
      check("pp1 timeout", to, 0);
      exp_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
      check_stream("pp1");
      check("pp1 bursts", bursts, 1);
      check("pp1 strobes", strobes, 1);
      check("pp1 sr_out", last_sr, 8'h00);

      // NOR page wrap splits into two bursts.
      mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC; mem[4] = 8'hDD;
      run_cmd(8'h02, 24'h0000FE, 12'd8, 8'h03, to);
      check("wrap timeout", to, 0);
      exp_q = '{8'h02, 8'h00, 8'h00, 8'hFE, 8'hAA, 8'hBB, 8'h02, 8'h00, 8'h00, 8'h00, 8'hCC, 8'hDD};
      check_stream("wrap");
      check("wrap bursts", bursts, 2);
      check("wrap gap", (gaps.size() == 1) ? gaps[0] : -1, 4);

      // Reject timing with WEL clear.
      start_cmd(8'h02, 24'h000010, 12'd8, 8'h01);
      check("rej check busy", busy, 1);
      check("rej check strobe", sr_strobe, 0);
      @(negedge clk);
      check("rej strobe", sr_strobe, 1);
      check("rej sr_out", sr_out, 8'h00);
      check("rej ram_req", ram_req, 0);
      wait_idle(to);
      check("rej timeout", to, 0);
      check("rej bursts", bursts, 0);

      // Grant loss after two data bytes; a strobe while busy must be dropped.
      mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'h44;
      start_cmd(8'h02, 24'h000010, 12'd8, 8'h03);
      cyc = 0;
      while ((got.size() < 6) && (cyc < 200)) begin
         @(negedge clk);
         cyc++;
      end
      check("gl reach", got.size(), 6);
      ram_grant = 1'b0;
      @(negedge clk);
      check("gl req drop", ram_req, 0);
      cmd        = 8'h20;
      cmd_addr   = 24'h000000;
      cmd_strobe = 1'b1;
      @(negedge clk);
      cmd_strobe = 1'b0;
      repeat (8) @(negedge clk);
      ram_grant = 1'b1;
      wait_idle(to);
      check("gl timeout", to, 0);
      exp_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h02, 8'h00, 8'h00, 8'h12, 8'h33, 8'h44};
      check_stream("gl");
      check("gl bursts", bursts, 2);
      check("gl strobes", strobes, 1);
      check("gl gap", (gaps.size() == 1) ? gaps[0] : -1, 4);

      // Reset in the middle of an erase.
      start_cmd(8'h20, 24'h800000, 12'd4, 8'h03);
      cyc = 0;
      while ((got.size() < 10) && (cyc < 200)) begin
         @(negedge clk);
         cyc++;
      end
      check("mr reach", (got.size() >= 10), 1);
      reset = 1'b0;
      #1;
      check("mr ram_req", ram_req, 0);
      check("mr busy", busy, 0);
      check("mr sr_strobe", sr_strobe, 0);
      check("mr tx_valid", ram_tx_valid, 0);
      repeat (3) @(negedge clk);
      reset   = 1'b1;
      strobes = 0;
      repeat (20) @(negedge clk);
      check("mr no strobe", strobes, 0);
      check("mr idle busy", busy, 0);
      run_cmd(8'h02, 24'h000010, 12'd8, 8'h03, to);
      check("mr new timeout", to, 0);
      check("mr new bytes", got.size(), 8);
      check("mr new strobes", strobes, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
